// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if: operand/handshake bundle between a feed controller and the skew feeder.
interface systolic_skew_feeder_if #(
  parameter int N = 2,
  parameter int DW = 8
) ();
  logic start;
  logic stall;
  logic [N*N*DW-1:0] a_mat;
  logic [N*N*DW-1:0] b_mat;
  logic busy;
  logic clear;
  logic [N*DW-1:0] a_out;
  logic [N*DW-1:0] b_out;
  logic feed_valid;
  logic done;
  modport master (output start, stall, a_mat, b_mat, input busy, clear, a_out, b_out, feed_valid, done);
  modport slave (input start, stall, a_mat, b_mat, output busy, clear, a_out, b_out, feed_valid, done);
endinterface

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: feeds row-skewed A and column-skewed B wavefronts into an NxN systolic array.
// Define FEEDER_STALL_EN to let bus.stall freeze the feed and drain phases.
module systolic_skew_feeder #(
  parameter int N = 2,
  parameter int DW = 8,
  parameter int DRAIN = 2
) (
  input logic clk,
  input logic rst_n,
  systolic_skew_feeder_if.slave bus
);
  localparam int TW = $clog2(2*N);
  localparam logic [TW-1:0] T_LAST = TW'(2*N-2);
  localparam logic [3:0] D_LAST = 4'(DRAIN-1);
  localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_FEED = 3'd2, S_DRAIN = 3'd3, S_DONE = 3'd4;
  localparam logic [2:0] S_POST = (DRAIN == 0) ? S_DONE : S_DRAIN;
  logic [2:0] r_state;
  logic [TW-1:0] r_t;
  logic [3:0] r_d;
  logic [N*N*DW-1:0] r_a, r_b;
  logic [N*DW-1:0] w_a, w_b, r_a_out, r_b_out;
  logic r_clear, r_busy, r_valid, r_done, w_stall;
`ifdef FEEDER_STALL_EN
  assign w_stall = bus.stall && (r_state == S_FEED || r_state == S_DRAIN);
`else
  assign w_stall = bus.stall & 1'b0;
`endif
  // element A[r][k] / B[k][c=r] meets its PE on the wavefront t = r + k
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++)
        if (r_state == S_FEED && int'(r_t) == r + k) begin
          w_a[r*DW +: DW] = r_a[(r*N+k)*DW +: DW];
          w_b[r*DW +: DW] = r_b[(k*N+r)*DW +: DW];
        end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_t <= '0;
      r_d <= '0;
      r_a <= '0;
      r_b <= '0;
    end else if (!w_stall)
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_a <= bus.a_mat;
          r_b <= bus.b_mat;
          r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          r_t <= '0;
          r_state <= S_FEED;
        end
        S_FEED: if (r_t == T_LAST) begin
          r_d <= '0;
          r_state <= S_POST;
        end else r_t <= r_t + 1'b1;
        S_DRAIN: if (r_d == D_LAST) r_state <= S_DONE; else r_d <= r_d + 1'b1;
        default: r_state <= S_IDLE;
      endcase
  // outputs trail the state by one cycle; a frozen state therefore holds them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_clear <= 1'b0;
      r_busy <= 1'b0;
      r_valid <= 1'b0;
      r_done <= 1'b0;
      r_a_out <= '0;
      r_b_out <= '0;
    end else begin
      r_clear <= r_state == S_CLEAR;
      r_busy <= r_state != S_IDLE;
      r_valid <= r_state == S_FEED;
      r_done <= r_state == S_DONE;
      r_a_out <= w_a;
      r_b_out <= w_b;
    end
  assign bus.clear = r_clear;
  assign bus.busy = r_busy;
  assign bus.feed_valid = r_valid;
  assign bus.done = r_done;
  assign bus.a_out = r_a_out;
  assign bus.b_out = r_b_out;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: scoreboard bench for the skew feeder at N=2/DRAIN=2, N=4/DW=16 and N=2/DRAIN=0.
module tb_systolic_skew_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0, tests = 0, fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  systolic_skew_feeder_if #(.N(2), .DW(8)) f0 ();
  systolic_skew_feeder_if #(.N(4), .DW(16)) f1 ();
  systolic_skew_feeder_if #(.N(2), .DW(8)) f2 ();
  systolic_skew_feeder #(.N(2), .DW(8), .DRAIN(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(f0));
  systolic_skew_feeder #(.N(4), .DW(16), .DRAIN(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(f1));
  systolic_skew_feeder #(.N(2), .DW(8), .DRAIN(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(f2));
  localparam logic [31:0] A0 = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [31:0] B0 = {8'd8, 8'd7, 8'd6, 8'd5};
  logic [31:0] e2x2 [3] = '{32'h0001_0005, 32'h0302_0607, 32'h0400_0800};
  logic [31:0] q0[$], q2[$];
  logic [127:0] q1[$];
  int dq0[$], dq1[$], dq2[$];
  int lv2 = 0, st1 = 0;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] step4(input logic [255:0] am, input logic [255:0] bm, input int t);
    logic [63:0] a, b;
    a = '0;
    b = '0;
    for (int r = 0; r < 4; r++) begin
      int k;
      k = t - r;
      if (k >= 0 && k < 4)
        for (int x = 0; x < 16; x++) begin
          a[r*16+x] = am[(r*4+k)*16+x];
          b[r*16+x] = bm[(k*4+r)*16+x];
        end
    end
    return {a, b};
  endfunction
  task automatic push0(input int rep);
    for (int t = 0; t < 3; t++)
      repeat ((t == 1) ? 1 + rep : 1) q0.push_back(e2x2[t]);
  endtask
  task automatic start0(output int s);
    @(negedge clk);
    f0.a_mat = A0;
    f0.b_mat = B0;
    f0.start = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    @(negedge clk);
    f0.start = 1'b0;
    f0.a_mat = '1;
    f0.b_mat = '1;
  endtask
  task automatic wait_done(input int which, input int n);
    int k, sz;
    k = 0;
    sz = (which == 0) ? dq0.size() : (which == 1) ? dq1.size() : dq2.size();
    while (sz < n && k < 200) begin
      @(posedge clk);
      k++;
      sz = (which == 0) ? dq0.size() : (which == 1) ? dq1.size() : dq2.size();
    end
    chk($sformatf("done_wait_u%0d", which), 256'(sz >= n), 256'd1);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (f0.done) dq0.push_back(cyc);
    if (f0.feed_valid) begin
      chk("u0_pending", 256'(q0.size() > 0), 256'd1);
      if (q0.size() > 0) chk("u0_step", {f0.a_out, f0.b_out}, q0.pop_front());
    end else chk("u0_idle_zero", {f0.a_out, f0.b_out}, '0);
  end
  always @(negedge clk) if (rst_n) begin
    if (f1.done) dq1.push_back(cyc);
    if (f1.clear) st1 = 0;
    if (f1.feed_valid) begin
      chk("u1_pending", 256'(q1.size() > 0), 256'd1);
      if (q1.size() > 0) chk("u1_step", {f1.a_out, f1.b_out}, q1.pop_front());
      chk("u1_lane3", {f1.a_out[63:48] != 0, f1.b_out[63:48] != 0}, (st1 >= 3) ? 2'b11 : 2'b00);
      st1++;
    end
  end
  always @(negedge clk) if (rst_n) begin
    if (f2.done) dq2.push_back(cyc);
    if (f2.feed_valid) begin
      lv2 = cyc;
      chk("u2_pending", 256'(q2.size() > 0), 256'd1);
      if (q2.size() > 0) chk("u2_step", {f2.a_out, f2.b_out}, q2.pop_front());
    end
  end
  initial begin
    int s;
    logic [255:0] am, bm;
    f0.start = 0; f0.stall = 0; f0.a_mat = '0; f0.b_mat = '0;
    f1.start = 0; f1.stall = 0; f1.a_mat = '0; f1.b_mat = '0;
    f2.start = 0; f2.stall = 0; f2.a_mat = '0; f2.b_mat = '0;
    repeat (3) @(negedge clk);
    chk("rst_u0", {f0.busy, f0.clear, f0.feed_valid, f0.done, f0.a_out, f0.b_out}, '0);
    chk("rst_u1", {f1.busy, f1.clear, f1.feed_valid, f1.done, f1.a_out, f1.b_out}, '0);
    chk("rst_u2", {f2.busy, f2.clear, f2.feed_valid, f2.done, f2.a_out, f2.b_out}, '0);
    rst_n = 1'b1;
    push0(0);
    start0(s);
    chk("u0_pre_clear", {f0.clear, f0.busy}, 2'b00);
    @(negedge clk);
    chk("u0_clear", {f0.clear, f0.feed_valid}, 2'b10);
    @(negedge clk);
    chk("u0_clear_once", {f0.clear, f0.busy, f0.feed_valid}, 3'b011);
    wait_done(0, 1);
    chk("u0_latency", dq0[0] - s + 1, 8);
    @(negedge clk);
    chk("u0_done_pulse", {f0.done, f0.busy}, 2'b00);
    chk("u0_drained", q0.size(), 0);
    dq0.delete();
    push0(0);
    push0(0);
    @(negedge clk);
    f0.a_mat = A0;
    f0.b_mat = B0;
    f0.start = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    repeat (8) @(posedge clk);
    @(negedge clk);
    f0.start = 1'b0;
    wait_done(0, 2);
    repeat (20) @(posedge clk);
    chk("u0_hold_runs", dq0.size(), 2);
    chk("u0_hold_lat1", dq0[0] - s + 1, 8);
    chk("u0_hold_lat2", dq0[1] - s + 1, 16);
    chk("u0_hold_drained", q0.size(), 0);
    dq0.delete();
    push0(0);
    start0(s);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    q0.delete();
    #1 chk("u0_rst_mid", {f0.busy, f0.clear, f0.feed_valid, f0.done, f0.a_out, f0.b_out}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("u0_rst_nodone", dq0.size(), 0);
    push0(0);
    start0(s);
    wait_done(0, 1);
    chk("u0_rst_relat", dq0[0] - s + 1, 8);
    chk("u0_rst_drained", q0.size(), 0);
    dq0.delete();
    am = '0;
    bm = '0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        am[(r*4+k)*16 +: 16] = 16'(16*r + k);
        bm[(r*4+k)*16 +: 16] = 16'(256 + 16*r + k);
      end
    for (int t = 0; t < 7; t++) q1.push_back(step4(am, bm, t));
    @(negedge clk);
    f1.a_mat = am;
    f1.b_mat = bm;
    f1.start = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    @(negedge clk);
    f1.start = 1'b0;
    wait_done(1, 1);
    chk("u1_latency", dq1[0] - s + 1, 12);
    chk("u1_drained", q1.size(), 0);
    chk("u1_steps", st1, 7);
    for (int t = 0; t < 3; t++) q2.push_back(e2x2[t]);
    @(negedge clk);
    f2.a_mat = A0;
    f2.b_mat = B0;
    f2.start = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    @(negedge clk);
    f2.start = 1'b0;
    wait_done(2, 1);
    chk("u2_latency", dq2[0] - s + 1, 6);
    chk("u2_no_gap", dq2[0], lv2 + 1);
    chk("u2_drained", q2.size(), 0);
`ifdef FEEDER_STALL_EN
    push0(3);
    start0(s);
    repeat (2) @(negedge clk);
    f0.stall = 1'b1;
    repeat (3) @(negedge clk);
    f0.stall = 1'b0;
    wait_done(0, 1);
    chk("u0_stall_lat", dq0[0] - s + 1, 11);
`else
    push0(0);
    start0(s);
    f0.stall = 1'b1;
    wait_done(0, 1);
    f0.stall = 1'b0;
    chk("u0_stall_ignored_lat", dq0[0] - s + 1, 8);
`endif
    repeat (4) @(posedge clk);
    chk("u0_stall_drained", q0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 SHALL have parameter N, default 2: systolic array dimension (rows of A = columns of B = N); legal range 2..8.
REQ-002 SHALL have parameter DW, default 8: operand element width in bits.
REQ-003 SHALL have parameter DRAIN, default 2: cycles waited after the last operand before done; legal range 0..15.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  request to capture operands and begin a feed; honoured only in IDLE.
REQ-007 a_mat  in  N*N*DW  matrix A, row-major; element A[r][k] at bits (r*N+k)*DW +: DW.
REQ-008 b_mat  in  N*N*DW  matrix B, row-major; element B[k][c] at bits (k*N+c)*DW +: DW.
REQ-009 stall  in  1  downstream hold request; active only when FEEDER_STALL_EN is defined.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 clear  out  1  one-cycle pulse instructing the array to zero its accumulators.
REQ-012 a_out  out  N*DW  row-skewed A stream; lane r at r*DW +: DW.
REQ-013 b_out  out  N*DW  column-skewed B stream; lane c at c*DW +: DW.
REQ-014 feed_valid  out  1  high on cycles where a_out/b_out carry a wavefront step.
REQ-015 done  out  1  one-cycle pulse on completion.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-017 IDLE: start=1 SHALL register a_mat and b_mat into internal operand buffers and move to CLEAR; later input changes SHALL NOT affect the feed in progress.
REQ-018 CLEAR: clear=1 for exactly one cycle, step counter t=0, then move to FEED.
REQ-019 FEED SHALL last 2N-1 advancing cycles with t = 0..2N-2 and feed_valid=1 in each.
REQ-020 At step t, lane r of a_out SHALL equal A[r][t-r] when 0 <= t-r < N, otherwise 0.
REQ-021 At step t, lane c of b_out SHALL equal B[t-c][c] when 0 <= t-c < N, otherwise 0.
REQ-022 All outputs SHALL be registered; the values for step t SHALL appear the cycle after the state/counter shows t.
REQ-023 After step 2N-2, the FSM SHALL enter DRAIN for DRAIN cycles; with DRAIN=0 it SHALL go directly to DONE.
REQ-024 In DRAIN, a_out, b_out and feed_valid SHALL be 0.
REQ-025 DONE SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-026 Start latency SHALL be 2N+DRAIN+2 cycles from the start edge to the done edge, with no stall.
REQ-027 start outside IDLE SHALL be ignored, with no queuing and no restart.
REQ-028 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted, giving back-to-back runs with one idle cycle between them.
REQ-029 The step counter SHALL be $clog2(2N) bits wide and SHALL NOT wrap within a run.
REQ-030 Operands SHALL pass through unmodified: no sign or width conversion.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, t=0, clear=0, busy=0, feed_valid=0, done=0, a_out=0, b_out=0, and zero the operand buffers.
REQ-032 Reset mid-run SHALL abandon the run with no done pulse; the first start after release SHALL begin a fresh run.

Configuration
REQ-033 Macro FEEDER_STALL_EN: when defined, stall=1 in FEED or DRAIN SHALL freeze t, the drain counter, the state and all outputs, holding their last values including feed_valid.
REQ-034 Stall behaviour with FEEDER_STALL_EN defined:
- stall=1 in CLEAR or DONE SHALL be ignored, so both pulses stay one cycle.
- Each stalled cycle SHALL extend the latency by one cycle.
REQ-035 Without FEEDER_STALL_EN, the stall port SHALL exist but be ignored, and latency SHALL always equal REQ-026.

Verification
REQ-036 N=2, DW=8, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse:
- clear pulse, then steps a_out=(1,0),(2,3),(0,4) and b_out=(5,0),(7,6),(0,8).
- done exactly 2N+DRAIN+2=8 cycles after the start edge.
REQ-037 start held high through a whole run -> exactly one run plus one restart accepted after DONE; start during FEED is not queued.
REQ-038 rst_n pulled low at FEED step 1 -> all outputs 0 immediately; no done; a new start after release gives the full REQ-036 sequence.
REQ-039 N=4, DW=16, A[r][k]=16*r+k, B[k][c]=0x100+16*k+c -> 7 valid steps matching REQ-020/021; lane 3 first nonzero at step 3; done at cycle 12.
REQ-040 FEEDER_STALL_EN defined, stall high for 3 cycles at step 1 -> step-1 outputs held 3 extra cycles; done delayed by 3 cycles; no values skipped.
REQ-041 DRAIN=0 with N=2 -> done 6 cycles after start, with no zero-output cycle between the last step and DONE.
